tra_state_fsm: RTL and testbench
================================

Name: tra_state_fsm

Overview:
- Timing and sequencing FSM for the highway/country-road crossing.
- Sits directly upstream of the lamp-driver stage and drives its 2-bit `current_state` input.
- Encoding:
  - 0: main green / country red
  - 1: main yellow / country red
  - 2: main red / country green
  - 3: main red / country yellow
- Derives a 1 s tick from `clk`, times each phase, and uses a country-road vehicle sensor to request and end the country green.

Parameters:
- TICK_DIV, 50000000, `clk` cycles per 1 s tick (≥2).
- MAIN_GREEN_MIN, 25, minimum main-green seconds (1..63).
- MAIN_YELLOW, 3, main-yellow seconds (1..63).
- CTRY_GREEN_MIN, 5, minimum country-green seconds (1..CTRY_GREEN_MAX).
- CTRY_GREEN_MAX, 15, maximum country-green seconds (1..63).
- CTRY_YELLOW, 3, country-yellow seconds (1..63).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- car_sensor  input  1  country-road vehicle present; asynchronous, level.
- current_state  output  2  phase code, as encoded in Overview.
- remaining  output  6  seconds left in the current phase, for the countdown display.
- state_chg  output  1  one-cycle pulse on the cycle `current_state` changes.
- tick  output  1  one-cycle 1 s strobe.

Behaviour:
- Reset: `rst` is asynchronous, active-high. Asserting `rst` asynchronously forces:
  - `current_state` = 0, `remaining` = MAIN_GREEN_MIN;
  - `state_chg` = 0, `tick` = 0;
  - prescaler = 0, both sensor sync flops = 0.
  - Reset mid-phase abandons the phase with no yellow.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` = 1 for the cycle in which the count equals TICK_DIV-1. First tick occurs TICK_DIV cycles after reset release.
- Sensor: `car_sensor` passes through a 2-flop synchronizer to give `car_s`. Only `car_s` is used, and only sampled on tick cycles.
- Phase entry: on entry to a phase, `remaining` loads that phase's duration:
  - state 0: MAIN_GREEN_MIN
  - state 1: MAIN_YELLOW
  - state 2: CTRY_GREEN_MAX
  - state 3: CTRY_YELLOW
- All updates happen only on tick cycles; between ticks, state and `remaining` hold.
- State 0:
  - If `remaining` > 1: decrement.
  - If `remaining` == 1 and `car_s` = 0: hold at 1.
  - If `remaining` == 1 and `car_s` = 1: go to state 1.
- State 1: decrement while > 1; when `remaining` == 1, go to state 2.
- State 2: go to state 3 if either:
  - `remaining` == 1 (max reached), or
  - `car_s` = 0 and elapsed ≥ CTRY_GREEN_MIN, i.e. `remaining` ≤ CTRY_GREEN_MAX - CTRY_GREEN_MIN + 1.
  - Otherwise decrement.
- State 3: decrement while > 1; when `remaining` == 1, go to state 0.
- Timing consequence: each timed phase lasts exactly its duration in ticks, except state 0 (extends indefinitely) and state 2 (early exit).
- Outputs: `current_state`, `remaining` and `state_chg` are registered. `state_chg` = 1 on the same cycle the new `current_state` first appears; otherwise 0.
- Illegal state: any illegal internal encoding recovers to state 0 with `remaining` = MAIN_GREEN_MIN on the next clock.

Optional Feature:
- Macro: EMERGENCY_EN.
- When defined:
  - Adds input `emerg` (1 bit, asynchronous), with its own 2-flop synchronizer giving `emerg_s`.
  - On a tick with `emerg_s` = 1:
    - State 2 goes immediately to state 3, ignoring CTRY_GREEN_MIN.
    - State 0 ignores `car_s` and holds, even at `remaining` == 1.
    - States 1 and 3 run to completion.
  - Net effect: main road held green while `emerg` stays high.
- When undefined: no `emerg` port; behaviour exactly as above.

Test Plan:
- Reset and tick (TICK_DIV=4):
  - Stimulus: assert `rst` mid-cycle, then release.
  - Required: `current_state`=0, `remaining`=25, `state_chg`=0 immediately; first `tick` on cycle 4 after release, then every 4 cycles.
- Main-green hold:
  - Stimulus: `car_sensor`=0 for 40 ticks.
  - Required: `remaining` counts 25→1 and stays at 1; `current_state` stays 0; `state_chg` never pulses.
- Full cycle:
  - Stimulus: `car_sensor`=1 constantly.
  - Required: state sequence 0(25 ticks)→1(3)→2(15)→3(3)→0. `state_chg` pulses once per transition. `remaining` reloads 3, 15, 3, 25 on entry.
- Early exit:
  - Stimulus: `car_sensor` drops to 0 on the 2nd tick of state 2.
  - Required: stays in state 2 until `remaining`=11 (5 ticks elapsed), then goes to state 3.
- Mid-phase reset:
  - Stimulus: `rst` pulse during state 3.
  - Required: immediate state 0 with `remaining`=25, no yellow, prescaler restarts from 0.
- EMERGENCY_EN:
  - Stimulus: raise `emerg` at the 3rd tick of state 2.
  - Required: next tick goes to state 3, then state 0, which holds while `emerg`=1 even with `car_sensor`=1.

Source files
------------

// File: rtl/tra_state_fsm.sv
// Highway/country-road crossing sequencer: 1 s prescaler, phase timers and sensor-driven country green.
// Optional EMERGENCY_EN adds the emerg input, which holds the main road green while it is high.
//
// state | meaning
// S_MG  | main green / country red, holds at 1 s until a country car is seen
// S_MY  | main yellow / country red
// S_CG  | main red / country green, ends at max time or early once the road is clear
// S_CY  | main red / country yellow
module tra_state_fsm #(
    parameter int TICK_DIV       = 50000000,
    parameter int MAIN_GREEN_MIN = 25,
    parameter int MAIN_YELLOW    = 3,
    parameter int CTRY_GREEN_MIN = 5,
    parameter int CTRY_GREEN_MAX = 15,
    parameter int CTRY_YELLOW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_sensor,
`ifdef EMERGENCY_EN
    input  logic       emerg,
`endif
    output logic [1:0] current_state,
    output logic [5:0] remaining,
    output logic       state_chg,
    output logic       tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [5:0] MG_LD    = 6'(MAIN_GREEN_MIN);
    localparam logic [5:0] MY_LD    = 6'(MAIN_YELLOW);
    localparam logic [5:0] CG_LD    = 6'(CTRY_GREEN_MAX);
    localparam logic [5:0] CY_LD    = 6'(CTRY_YELLOW);
    // Country green has run its minimum once remaining falls to this value.
    localparam logic [5:0] CG_EARLY = 6'(CTRY_GREEN_MAX - CTRY_GREEN_MIN + 1);

    typedef enum logic [1:0] {
        S_MG = 2'd0,
        S_MY = 2'd1,
        S_CG = 2'd2,
        S_CY = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    rem_q, rem_d;
    logic          chg_q;
    logic [CW-1:0] cnt_q;
    logic          tick_w;
    logic [1:0]    car_sync;
    logic          car_s;
    logic          emerg_s;

    assign tick_w = (cnt_q == CW'(TICK_DIV - 1));
    assign car_s  = car_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick_w) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_sync <= 2'b00;
        end else begin
            car_sync <= {car_sync[0], car_sensor};
        end
    end

`ifdef EMERGENCY_EN
    logic [1:0] emerg_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            emerg_sync <= 2'b00;
        end else begin
            emerg_sync <= {emerg_sync[0], emerg};
        end
    end

    assign emerg_s = emerg_sync[1];
`else
    assign emerg_s = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_MG;
            rem_q   <= MG_LD;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            chg_q   <= (state_d != state_q);
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            S_MG: begin
                if (tick_w) begin
                    if (rem_q > 6'd1) begin
                        rem_d = rem_q - 6'd1;
                    end else if (car_s && !emerg_s) begin
                        state_d = S_MY;
                        rem_d   = MY_LD;
                    end
                end
            end
            S_MY: begin
                if (tick_w) begin
                    if (rem_q > 6'd1) begin
                        rem_d = rem_q - 6'd1;
                    end else begin
                        state_d = S_CG;
                        rem_d   = CG_LD;
                    end
                end
            end
            S_CG: begin
                if (tick_w) begin
                    if (rem_q <= 6'd1 || emerg_s || (!car_s && rem_q <= CG_EARLY)) begin
                        state_d = S_CY;
                        rem_d   = CY_LD;
                    end else begin
                        rem_d = rem_q - 6'd1;
                    end
                end
            end
            S_CY: begin
                if (tick_w) begin
                    if (rem_q > 6'd1) begin
                        rem_d = rem_q - 6'd1;
                    end else begin
                        state_d = S_MG;
                        rem_d   = MG_LD;
                    end
                end
            end
            default: begin
                state_d = S_MG;
                rem_d   = MG_LD;
            end
        endcase
    end

    always_comb begin
        current_state = state_q;
        remaining     = rem_q;
        state_chg     = chg_q;
        tick          = tick_w;
    end

endmodule

// File: tb/tb_tra_state_fsm.sv
// Scoreboard bench for tra_state_fsm with a 4-cycle tick; covers the emerg input when EMERGENCY_EN is defined.
module tb_tra_state_fsm;

    localparam int TD   = 4;
    localparam int MG   = 25;
    localparam int MY   = 3;
    localparam int CMIN = 5;
    localparam int CMAX = 15;
    localparam int CY   = 3;

    typedef struct packed {
        logic [1:0] st;
        logic [5:0] rem;
        logic       chg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       car_sensor = 1'b0;
    logic       emerg = 1'b0;
    logic [1:0] current_state;
    logic [5:0] remaining;
    logic       state_chg;
    logic       tick;

    always #5 clk = ~clk;

    tra_state_fsm #(
        .TICK_DIV(TD),
        .MAIN_GREEN_MIN(MG),
        .MAIN_YELLOW(MY),
        .CTRY_GREEN_MIN(CMIN),
        .CTRY_GREEN_MAX(CMAX),
        .CTRY_YELLOW(CY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .car_sensor(car_sensor),
`ifdef EMERGENCY_EN
        .emerg(emerg),
`endif
        .current_state(current_state),
        .remaining(remaining),
        .state_chg(state_chg),
        .tick(tick)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb_q[$];
    exp_t e;
    bit   mon_en = 1'b0;
    int   m_cnt, m_st, m_rem, ns, nr, chg_seen;
    bit   em_now;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: predicts the outputs visible after the next clock edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("state", current_state, e.st);
                chk("remaining", remaining, e.rem);
                chk("state_chg", state_chg, e.chg);
            end
            chg_seen += int'(state_chg);
            chk("tick", tick, int'(m_cnt == TD - 1));
`ifdef EMERGENCY_EN
            em_now = emerg;
`else
            em_now = 1'b0;
`endif
            ns = m_st;
            nr = m_rem;
            if (m_cnt == TD - 1) begin
                m_cnt = 0;
                case (m_st)
                    0: if (m_rem > 1) nr = m_rem - 1;
                       else if (car_sensor && !em_now) begin ns = 1; nr = MY; end
                    1: if (m_rem > 1) nr = m_rem - 1;
                       else begin ns = 2; nr = CMAX; end
                    2: if (m_rem == 1 || em_now || (!car_sensor && m_rem <= CMAX - CMIN + 1)) begin
                           ns = 3; nr = CY;
                       end else nr = m_rem - 1;
                    default: if (m_rem > 1) nr = m_rem - 1;
                             else begin ns = 0; nr = MG; end
                endcase
            end else begin
                m_cnt++;
            end
            sb_q.push_back('{st: 2'(ns), rem: 6'(nr), chg: (ns != m_st)});
            m_st  = ns;
            m_rem = nr;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst    = 1'b1;
        mon_en = 1'b0;
        sb_q.delete();
        #1;
        chk("rst_state", current_state, 0);
        chk("rst_remaining", remaining, MG);
        chk("rst_state_chg", state_chg, 0);
        chk("rst_tick", tick, 0);
        @(posedge clk);
        #2;
        rst      = 1'b0;
        m_cnt    = 0;
        m_st     = 0;
        m_rem    = MG;
        chg_seen = 0;
        sb_q.push_back('{st: 2'd0, rem: 6'(MG), chg: 1'b0});
        mon_en   = 1'b1;
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 2 * TD + 2 && !seen; i++) begin
            @(negedge clk);
            if (tick) seen = 1'b1;
        end
        if (!seen) chk("tick_timeout", 0, 1);
    endtask

    task automatic wait_state(input int s, input int max_ticks);
        bit seen = 1'b0;
        for (int i = 0; i < (max_ticks + 1) * TD && !seen; i++) begin
            @(negedge clk);
            if (current_state == 2'(s)) seen = 1'b1;
        end
        if (!seen) chk("state_timeout", 0, s);
    endtask

    initial begin
        int n;
        do_reset();

        // Main green holds at 1 s with no country car.
        repeat (40) wait_tick();
        chk("hold_state", current_state, 0);
        chk("hold_remaining", remaining, 1);
        chk("hold_no_chg", chg_seen, 0);

        // Full cycle with a car always waiting.
        wait_tick();
        #1 car_sensor = 1'b1;
        chg_seen = 0;
        wait_state(1, 2);
        wait_state(2, 4);
        wait_state(3, 16);
        wait_state(0, 4);
        @(negedge clk);
        chk("cycle_chg_count", chg_seen, 4);

        // Early exit: car leaves after the second tick of country green.
        wait_state(2, 30);
        wait_tick();
        wait_tick();
        #1 car_sensor = 1'b0;
        n = 2;
        for (int i = 0; i < 20 && current_state != 2'd3; i++) begin
            wait_tick();
            n++;
            @(negedge clk);
        end
        chk("early_exit_ticks", n, 5);
        chk("early_exit_state", current_state, 3);

        // Reset in the middle of country yellow.
        wait_tick();
        do_reset();
        repeat (3) wait_tick();
        chk("post_rst_state", current_state, 0);
        chk("post_rst_remaining", remaining, MG - 2);

`ifdef EMERGENCY_EN
        #1 car_sensor = 1'b1;
        wait_state(2, 30);
        repeat (3) wait_tick();
        #1 emerg = 1'b1;
        wait_state(3, 2);
        wait_state(0, 4);
        repeat (40) wait_tick();
        chk("emerg_hold_state", current_state, 0);
        chk("emerg_hold_remaining", remaining, 1);
        #1 emerg = 1'b0;
        wait_state(1, 4);
`endif

        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
